mvm_job_arbiter: RTL and testbench

Round-robin job arbiter that shares one matrix-vector-multiply engine between NREQ independent requesters. Each requester streams a complete job, matrix A, then B, then X, as 8-bit elements. The arbiter locks the engine's input stream to one owner for the whole job, then routes that job's 16-bit results and overflow flags back to the same owner. It sits between the requester-side stream fabric and a single `mvm3` engine instance.

---
 rtl/mvm_job_arbiter_pkg.sv | 20 ++
 rtl/mvm_job_arbiter_rr_pick.sv | 28 ++
 rtl/mvm_job_arbiter.sv | 129 ++++++++++++
 tb/tb_mvm_job_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_job_arbiter_pkg.sv
// Shared definitions for the MVM job arbiter: engine matrix geometry, derived job
// sizes and the arbiter state type.
package defines_pkg;

  localparam int unsigned NROWS_A = 4;
  localparam int unsigned NCOLS_A = 4;
  localparam int unsigned NROWS_B = 4;
  localparam int unsigned NCOLS_B = 4;

  // A, then B, then X (X has the same size as B)
  localparam int unsigned JOB_LEN     = NROWS_A * NCOLS_A + 2 * NROWS_B * NCOLS_B;
  localparam int unsigned RES_PER_JOB = NROWS_A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mvm_job_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request at or
// after the pointer, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned  NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic [IW-1:0]   o_grant,
  output logic            o_found
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IW'((32'(i_rr_ptr) + k) % NREQ);
      if (!o_found && i_req[w_idx]) begin
        o_found = 1'b1;
        o_grant = w_idx;
      end
    end
  end

endmodule

// File: rtl/mvm_job_arbiter.sv
// Round-robin arbiter sharing one mvm3 engine: locks the input stream to one
// requester for a whole job, then routes that job's results back to it.
module mvm_job_arbiter #(
  parameter int unsigned  NREQ        = 4,
  parameter int unsigned  JOB_LEN     = defines_pkg::JOB_LEN,
  parameter int unsigned  RES_PER_JOB = defines_pkg::RES_PER_JOB,
  localparam int unsigned IW          = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0] req_ready,
  output logic [NREQ-1:0] res_valid,
  output logic [15:0]     res_data,
  output logic            res_overflow,
  input  logic [NREQ-1:0] res_ready,
  output logic            eng_s_valid,
  output logic [7:0]      eng_data_in,
  input  logic            eng_s_ready,
  input  logic            eng_m_valid,
  input  logic [15:0]     eng_data_out,
  input  logic            eng_overflow,
  output logic            eng_m_ready,
  output logic [IW-1:0]   owner,
  output logic            busy,
  output logic            job_done
);

  localparam int unsigned EW = (JOB_LEN > 1) ? $clog2(JOB_LEN) : 1;
  localparam int unsigned RW = (RES_PER_JOB > 1) ? $clog2(RES_PER_JOB) : 1;

  defines_pkg::arb_state_t r_state, w_next;
  logic [IW-1:0] r_owner, r_rr_ptr, w_grant;
  logic          w_found;
  logic [EW-1:0] r_ecnt;
  logic [RW-1:0] r_rcnt;
  logic [7:0]    w_sel_data;
  logic          w_in_hs, w_res_hs, w_last_in, w_last_res;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_grant  (w_grant),
    .o_found  (w_found)
  );

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == r_owner) w_sel_data = req_data[i*8 +: 8];
    end
  end

  assign w_in_hs    = (r_state == defines_pkg::ST_LOAD) && req_valid[r_owner] && eng_s_ready;
  assign w_res_hs   = (r_state == defines_pkg::ST_DRAIN) && eng_m_valid && res_ready[r_owner];
  assign w_last_in  = (r_ecnt == EW'(JOB_LEN - 1));
  assign w_last_res = (r_rcnt == RW'(RES_PER_JOB - 1));

  assign owner        = r_owner;
  assign busy         = (r_state != defines_pkg::ST_IDLE);
  assign res_data     = eng_data_out;
  assign res_overflow = eng_overflow;

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    res_valid   = '0;
    eng_s_valid = 1'b0;
    eng_data_in = '0;
    eng_m_ready = 1'b0;
    job_done    = 1'b0;
    unique case (r_state)
      defines_pkg::ST_IDLE: begin
        if (w_found) w_next = defines_pkg::ST_LOAD;
      end
      defines_pkg::ST_LOAD: begin
        // valid is never gated by engine ready; only the owner sees ready
        eng_s_valid        = req_valid[r_owner];
        eng_data_in        = w_sel_data;
        req_ready[r_owner] = eng_s_ready;
        if (w_in_hs && w_last_in) w_next = defines_pkg::ST_DRAIN;
      end
      defines_pkg::ST_DRAIN: begin
        res_valid[r_owner] = eng_m_valid;
        eng_m_ready        = res_ready[r_owner];
        if (w_res_hs && w_last_res) begin
          job_done = 1'b1;
          w_next   = defines_pkg::ST_IDLE;
        end
      end
      default: w_next = defines_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= defines_pkg::ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_ecnt   <= '0;
      r_rcnt   <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        defines_pkg::ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_grant;
            r_ecnt  <= '0;
          end
        end
        defines_pkg::ST_LOAD: begin
          if (w_in_hs) begin
            r_ecnt <= r_ecnt + 1'b1;
            if (w_last_in) r_rcnt <= '0;
          end
        end
        defines_pkg::ST_DRAIN: begin
          if (w_res_hs) begin
            r_rcnt <= r_rcnt + 1'b1;
            if (w_last_res) r_rr_ptr <= (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_job_arbiter.sv
// Randomized scoreboard bench for mvm_job_arbiter with a job-level reference
// model of the grant order and a behavioural stand-in for the mvm3 engine.
module tb_mvm_job_arbiter;

  localparam int NREQ = 4;
  localparam int JL   = 48;
  localparam int RP   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready, res_valid, res_ready;
  logic [NREQ*8-1:0] req_data;
  logic [15:0]       res_data, eng_data_out;
  logic              res_overflow, eng_overflow;
  logic              eng_s_valid, eng_s_ready, eng_m_valid, eng_m_ready;
  logic [7:0]        eng_data_in;
  logic [1:0]        owner;
  logic              busy, job_done;

  always #5 clk = ~clk;

  mvm_job_arbiter #(.NREQ(NREQ), .JOB_LEN(JL), .RES_PER_JOB(RP)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_overflow(res_overflow),
    .res_ready(res_ready),
    .eng_s_valid(eng_s_valid), .eng_data_in(eng_data_in), .eng_s_ready(eng_s_ready),
    .eng_m_valid(eng_m_valid), .eng_data_out(eng_data_out), .eng_overflow(eng_overflow),
    .eng_m_ready(eng_m_ready),
    .owner(owner), .busy(busy), .job_done(job_done)
  );

  int total = 0;
  int bad   = 0;

  // requester side: job contents and per-requester expected element streams
  logic [7:0] jd    [NREQ][JL];
  logic [7:0] exp_q [NREQ][$];
  int         jobs_left [NREQ];
  bit         rq_active [NREQ];
  int         rq_idx    [NREQ];
  bit         full_mode;

  // engine stand-in and expected result stream
  int          eng_in_cnt, eng_out_idx, shown_idx, job_serial;
  bit          eng_out_mode;
  logic [15:0] ev [RP];
  logic        eo [RP];
  logic [16:0] res_q[$];

  // job-level reference model
  typedef enum {M_IDLE, M_LOAD, M_DRAIN} mst_t;
  mst_t m_st;
  int   m_owner, m_ptr, jobs_done;
  int   glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: samples on the falling edge, pops expectations on handshakes
  initial begin
    m_st = M_IDLE; m_ptr = 0; m_owner = 0; jobs_done = 0;
    forever begin
      logic [NREQ-1:0] er;
      logic [16:0]     x;
      bit              hs, last;
      @(negedge clk);
      if (reset) begin
        m_st = M_IDLE; m_ptr = 0; m_owner = 0;
        continue;
      end
      chk("res_data_pass", res_data, eng_data_out);
      chk("res_ovf_pass", res_overflow, eng_overflow);
      case (m_st)
        M_IDLE: begin
          chk("idle_busy", busy, 0);
          chk("idle_req_ready", req_ready, 0);
          chk("idle_eng_s_valid", eng_s_valid, 0);
          chk("idle_eng_m_ready", eng_m_ready, 0);
          chk("idle_res_valid", res_valid, 0);
          chk("idle_job_done", job_done, 0);
          for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) begin
              m_owner = i; m_st = M_LOAD; glog.push_back(i);
              break;
            end
          end
        end
        M_LOAD: begin
          er = '0; er[m_owner] = eng_s_ready;
          chk("load_busy", busy, 1);
          chk("load_owner", owner, m_owner);
          chk("load_req_ready", req_ready, er);
          chk("load_eng_s_valid", eng_s_valid, req_valid[m_owner]);
          chk("load_eng_m_ready", eng_m_ready, 0);
          chk("load_res_valid", res_valid, 0);
          chk("load_job_done", job_done, 0);
          hs = req_valid[m_owner] && eng_s_ready;
          if (hs) begin
            eng_in_cnt++;
            if (exp_q[m_owner].size() == 0) chk("elem_underflow", 1, 0);
            else chk("eng_data_in", eng_data_in, exp_q[m_owner].pop_front());
            rq_idx[m_owner]++;
            if (rq_idx[m_owner] >= JL) rq_active[m_owner] = 1'b0;
            if (exp_q[m_owner].size() == 0) m_st = M_DRAIN;
          end
        end
        M_DRAIN: begin
          er = '0; er[m_owner] = eng_m_valid;
          chk("drain_busy", busy, 1);
          chk("drain_owner", owner, m_owner);
          chk("drain_req_ready", req_ready, 0);
          chk("drain_eng_s_valid", eng_s_valid, 0);
          chk("drain_res_valid", res_valid, er);
          chk("drain_eng_m_ready", eng_m_ready, res_ready[m_owner]);
          hs = eng_m_valid && res_ready[m_owner];
          if (hs) begin
            if (res_q.size() == 0) chk("res_underflow", 1, 0);
            else begin
              x = res_q.pop_front();
              chk("res_data", res_data, x[15:0]);
              chk("res_overflow", res_overflow, x[16]);
            end
            eng_out_idx++;
            last = (res_q.size() == 0);
            chk("job_done", job_done, last);
            if (last) begin
              jobs_done++;
              m_ptr = (m_owner + 1) % NREQ;
              m_st  = M_IDLE;
            end
          end else chk("drain_job_done", job_done, 0);
        end
        default: ;
      endcase
    end
  end

  task automatic drive();
    @(posedge clk); #1;
    if (!eng_out_mode && eng_in_cnt == JL) begin
      for (int k = 0; k < RP; k++) begin
        ev[k] = (k == 0 && job_serial % 2 == 0) ? 16'h7FF0 : 16'($urandom);
        eo[k] = (k == 0 && job_serial % 2 == 0) ? 1'b1 : 1'($urandom);
        res_q.push_back({eo[k], ev[k]});
      end
      eng_out_mode = 1'b1; eng_in_cnt = 0; eng_out_idx = 0; shown_idx = -1;
      job_serial++;
    end
    if (eng_out_mode && eng_out_idx >= RP) eng_out_mode = 1'b0;
    if (eng_out_mode) begin
      if (!(eng_m_valid && shown_idx == eng_out_idx)) eng_m_valid = ($urandom % 3 != 0);
      if (eng_m_valid) shown_idx = eng_out_idx;
      eng_data_out = ev[eng_out_idx];
      eng_overflow = eo[eng_out_idx];
    end else begin
      eng_m_valid  = ($urandom % 4 == 0);
      eng_data_out = 16'($urandom);
      eng_overflow = 1'($urandom);
    end
    eng_s_ready = ($urandom % 4 != 0);
    res_ready   = NREQ'($urandom);
    for (int r = 0; r < NREQ; r++) begin
      if (!rq_active[r] && jobs_left[r] > 0 && (full_mode || $urandom % 3 == 0)) begin
        for (int e = 0; e < JL; e++) begin
          jd[r][e] = 8'($urandom);
          exp_q[r].push_back(jd[r][e]);
        end
        rq_active[r] = 1'b1; rq_idx[r] = 0; jobs_left[r]--;
      end
      if (rq_active[r]) begin
        req_valid[r]       = full_mode ? 1'b1 : ($urandom % 6 != 0);
        req_data[r*8 +: 8] = jd[r][rq_idx[r]];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[r*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int r = 0; r < NREQ; r++) begin
      rq_active[r] = 1'b0; jobs_left[r] = 0; rq_idx[r] = 0; exp_q[r].delete();
    end
    res_q.delete();
    eng_in_cnt = 0; eng_out_idx = 0; eng_out_mode = 1'b0; shown_idx = -1;
    req_valid = '0; eng_m_valid = 1'b0; eng_s_ready = 1'b0; res_ready = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic run_jobs(input string nm, input int target, input int limit);
    int start, c;
    start = jobs_done; c = 0;
    while (jobs_done - start < target && c < limit) begin
      drive();
      c++;
    end
    chk(nm, jobs_done - start, target);
  endtask

  initial begin
    int sum, c;
    reset = 1'b1; full_mode = 1'b0; job_serial = 0;
    req_valid = '0; req_data = '0; res_ready = '0;
    eng_s_ready = 1'b0; eng_m_valid = 1'b0; eng_data_out = '0; eng_overflow = 1'b0;
    eng_in_cnt = 0; eng_out_idx = 0; eng_out_mode = 1'b0; shown_idx = -1;
    for (int r = 0; r < NREQ; r++) begin
      jobs_left[r] = 0; rq_active[r] = 1'b0; rq_idx[r] = 0;
    end
    do_reset();

    // single job from requester 2
    glog.delete();
    jobs_left[2] = 1;
    run_jobs("p1_jobs", 1, 2000);
    chk("p1_grant", glog.size() > 0 ? glog[0] : -1, 2);

    // simultaneous 0 and 3 from pointer 0, then fairness with pointer back at 0
    do_reset();
    glog.delete();
    full_mode = 1'b1;
    jobs_left[0] = 1; jobs_left[3] = 1;
    run_jobs("p2_jobs", 2, 4000);
    chk("p2_cnt", glog.size(), 2);
    chk("p2_first", glog.size() > 0 ? glog[0] : -1, 0);
    chk("p2_second", glog.size() > 1 ? glog[1] : -1, 3);

    glog.delete();
    for (int r = 0; r < NREQ; r++) jobs_left[r] = 2;
    run_jobs("p3_jobs", 8, 8000);
    chk("p3_cnt", glog.size(), 8);
    for (int j = 0; j < 8; j++) chk("p3_order", glog.size() > j ? glog[j] : -1, j % NREQ);

    // random traffic, stalls and back-pressure
    full_mode = 1'b0;
    sum = 0;
    for (int r = 0; r < NREQ; r++) begin
      jobs_left[r] = 1 + int'($urandom_range(2));
      sum += jobs_left[r];
    end
    run_jobs("p4_jobs", sum, 40000);

    // reset in the middle of a load; pointer was left at 3 beforehand
    jobs_left[2] = 1;
    run_jobs("p5_pre_jobs", 1, 2000);
    jobs_left[1] = 1;
    c = 0;
    while (rq_idx[1] < 30 && c < 2000) begin
      drive();
      c++;
    end
    chk("p5_reached_30", rq_idx[1] >= 30, 1);
    do_reset();
    glog.delete();
    full_mode = 1'b1;
    jobs_left[1] = 1; jobs_left[3] = 1;
    run_jobs("p5_jobs", 2, 4000);
    chk("p5_first", glog.size() > 0 ? glog[0] : -1, 1);
    chk("p5_second", glog.size() > 1 ? glog[1] : -1, 3);

    full_mode = 1'b0;
    repeat (3) drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
